// File: rtl/sample_averager_pkg.sv
// Shared definitions for the ADC measurement controller and its averaging stage.
// State codes and widths live here so the controller and the averager agree on them.
package sample_averager_pkg;

    // Width of the controller state register is STATE_SIZE+1 bits
    localparam int STATE_SIZE = 1;

    // Samples per averaging window; the mean is formed with a 2-bit right shift
    localparam int AVG_N = 4;

    // Native ADC conversion width
    localparam int ADC_W = 12;

    // Controller state codes; code 2'd3 is unused and treated like HOLD downstream
    typedef enum logic [STATE_SIZE:0] {
        MEAS    = 2'd0,
        HOLD    = 2'd1,
        AVERAGE = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/sample_averager.sv
// Accumulates four ADC samples while the controller is in MEAS, reports the fill
// level back to the controller, and on entry to AVERAGE publishes the floor mean.
// The display value follows live samples in MEAS and freezes everywhere else.
module sample_averager
    import sample_averager_pkg::*;
#(
    parameter int DATA_W = ADC_W,
    parameter int N_AVG  = AVG_N
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STATE_SIZE:0]   state_reg,
    input  logic [DATA_W-1:0]     sample,
    input  logic                  sample_valid,
    output logic [2:0]            hold_count,
    output logic [DATA_W-1:0]     avg,
    output logic                  avg_valid,
    output logic [DATA_W-1:0]     disp_value
);

    logic [DATA_W+1:0]   r_acc;
    logic [STATE_SIZE:0] r_prevState;
    logic [2:0]          r_holdCount;
    logic [DATA_W-1:0]   r_avg;
    logic                r_avgValid;
    logic [DATA_W-1:0]   r_dispValue;

    logic                w_avgEntry;
    logic                w_acceptSample;
    logic [DATA_W-1:0]   w_mean;

    // Decode the two events that can change state this cycle; entry always wins
    always_comb begin
        w_avgEntry     = (state_reg == AVERAGE) && (r_prevState != AVERAGE);
        w_acceptSample = !w_avgEntry
                         && (state_reg == MEAS)
                         && sample_valid
                         && (r_holdCount < 3'(N_AVG));
        w_mean         = r_acc[DATA_W+1:2];
    end

    // Window accumulation, AVERAGE-entry publish, and freeze in every other state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_prevState <= MEAS;
            r_holdCount <= '0;
            r_avg       <= '0;
            r_avgValid  <= 1'b0;
            r_dispValue <= '0;
        end else begin
            r_prevState <= state_reg;
            r_avgValid  <= 1'b0;
            if (w_avgEntry) begin
                r_avg       <= w_mean;
                r_avgValid  <= 1'b1;
                r_dispValue <= w_mean;
                r_acc       <= '0;
                r_holdCount <= '0;
            end else if (w_acceptSample) begin
                r_acc       <= r_acc + {2'b00, sample};
                r_holdCount <= r_holdCount + 3'd1;
                r_dispValue <= sample;
            end
        end
    end

    assign hold_count = r_holdCount;
    assign avg        = r_avg;
    assign avg_valid  = r_avgValid;
    assign disp_value = r_dispValue;

endmodule

// File: tb/tb_sample_averager.sv
// Directed bench for sample_averager: stimulus tasks push the expected mean into a
// scoreboard whenever they drive an AVERAGE entry, and an independent monitor pops
// and compares each time the DUT pulses avg_valid.
module tb_sample_averager;
    import sample_averager_pkg::*;

    logic                clk;
    logic                rst;
    logic [STATE_SIZE:0] stateReg;
    logic [ADC_W-1:0]    sample;
    logic                sampleValid;
    logic [2:0]          holdCount;
    logic [ADC_W-1:0]    avg;
    logic                avgValid;
    logic [ADC_W-1:0]    dispValue;

    int totalChecks = 0;
    int badChecks   = 0;
    int pulsesSeen  = 0;
    int pulsesWant  = 0;

    logic [ADC_W-1:0] expQueue[$];

    sample_averager #(.DATA_W(ADC_W), .N_AVG(AVG_N)) dut (
        .clk          (clk),
        .rst          (rst),
        .state_reg    (stateReg),
        .sample       (sample),
        .sample_valid (sampleValid),
        .hold_count   (holdCount),
        .avg          (avg),
        .avg_valid    (avgValid),
        .disp_value   (dispValue)
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single point where comparisons are counted and failures reported
    task automatic checkOutput(input string name, input int unsigned actual, input int unsigned expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got=%0d want=%0d", name, actual, expected);
        end
    endtask

    // Advance one clock and leave inputs/outputs settled 1 unit past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle sample strobe in whatever state is currently driven
    task automatic applyStimulus(input logic [ADC_W-1:0] value);
        sample      = value;
        sampleValid = 1'b1;
        tick();
        sampleValid = 1'b0;
    endtask

    // Drive AVERAGE for the given number of cycles, queueing the expected mean first;
    // optionally strobe a sample on every AVERAGE cycle including the entry edge
    task automatic runAverage(input logic [ADC_W-1:0] expMean, input int cycles, input bit strobe);
        expQueue.push_back(expMean);
        pulsesWant++;
        stateReg    = AVERAGE;
        sample      = 12'd4095;
        sampleValid = strobe;
        for (int i = 0; i < cycles; i++) tick();
        sampleValid = 1'b0;
        checkOutput("hold_count_after_avg", holdCount, 0);
        checkOutput("avg_held", avg, expMean);
        stateReg = MEAS;
    endtask

    // Scoreboard monitor: every avg_valid pulse must match the oldest queued mean
    always @(negedge clk) begin
        if (!rst && avgValid) begin
            pulsesSeen++;
            if (expQueue.size() == 0) begin
                totalChecks++;
                badChecks++;
                $display("[TB] FAIL unexpected_avg_valid: got avg=%0d want=no pulse", avg);
            end else begin
                logic [ADC_W-1:0] want;
                want = expQueue.pop_front();
                checkOutput("avg_value", avg, want);
                checkOutput("disp_on_avg", dispValue, want);
                checkOutput("hold_count_on_avg", holdCount, 0);
            end
        end
    end

    // Directed scenario sequence
    initial begin
        logic [ADC_W-1:0] basicVec[4];
        basicVec = '{12'd100, 12'd200, 12'd300, 12'd400};

        rst         = 1'b1;
        stateReg    = MEAS;
        sample      = '0;
        sampleValid = 1'b0;
        #12;
        checkOutput("reset_hold_count", holdCount, 0);
        checkOutput("reset_avg", avg, 0);
        checkOutput("reset_avg_valid", avgValid, 0);
        checkOutput("reset_disp", dispValue, 0);
        rst = 1'b0;
        tick();

        $display("[TB] basic average");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(basicVec[i]);
            checkOutput("basic_hold_count", holdCount, i + 1);
            checkOutput("basic_disp_live", dispValue, basicVec[i]);
        end
        tick();
        runAverage(12'd250, 2, 1'b0);

        $display("[TB] full scale and floor");
        for (int i = 0; i < 4; i++) applyStimulus(12'd4095);
        checkOutput("full_hold_count", holdCount, 4);
        runAverage(12'd4095, 1, 1'b0);
        applyStimulus(12'd1);
        applyStimulus(12'd1);
        applyStimulus(12'd1);
        applyStimulus(12'd2);
        runAverage(12'd1, 1, 1'b0);

        $display("[TB] hold freeze");
        applyStimulus(12'd10);
        applyStimulus(12'd20);
        stateReg = HOLD;
        for (int i = 0; i < 3; i++) applyStimulus(12'd999);
        checkOutput("hold_count_frozen", holdCount, 2);
        checkOutput("hold_disp_frozen", dispValue, 20);
        stateReg = 2'd3;
        applyStimulus(12'd999);
        checkOutput("undef_state_count", holdCount, 2);
        checkOutput("undef_state_disp", dispValue, 20);
        stateReg = MEAS;
        applyStimulus(12'd30);
        applyStimulus(12'd40);
        checkOutput("resume_hold_count", holdCount, 4);
        runAverage(12'd25, 1, 1'b0);

        $display("[TB] saturation and collision");
        applyStimulus(12'd5);
        applyStimulus(12'd6);
        applyStimulus(12'd7);
        applyStimulus(12'd8);
        applyStimulus(12'd4095);
        checkOutput("sat_hold_count", holdCount, 4);
        checkOutput("sat_disp", dispValue, 8);
        runAverage(12'd6, 10, 1'b1);

        $display("[TB] async reset mid-window");
        applyStimulus(12'd50);
        applyStimulus(12'd60);
        applyStimulus(12'd70);
        checkOutput("pre_reset_hold_count", holdCount, 3);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_hold_count", holdCount, 0);
        checkOutput("async_avg", avg, 0);
        checkOutput("async_disp", dispValue, 0);
        #3;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(12'd8);
        checkOutput("fresh_hold_count", holdCount, 4);
        runAverage(12'd8, 2, 1'b0);

        tick();
        tick();
        checkOutput("pulse_count", pulsesSeen, pulsesWant);
        checkOutput("scoreboard_drained", expQueue.size(), 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
